// File: rtl/q16_mem_pkg.sv
// Shared definitions for the data-RAM port arbiter: port indices, FSM encoding, latency bounds.
package q16_mem_pkg;

    localparam int unsigned NUM_PORTS = 3;

    // Requester port indices
    localparam int unsigned P_INT = 0;  // interrupt / stack context
    localparam int unsigned P_CPU = 1;  // normal CPU load/store
    localparam int unsigned P_DMA = 2;  // DMA / peripheral copier

    // Legal RAM read latency range
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StRwait = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for the data-RAM arbiter.
interface ram_port_arbiter_if import q16_mem_pkg::*; #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [ADDR_W-1:0]           ram_addr;
    logic [DATA_W-1:0]           ram_wdata;
    logic                        ram_w;
    logic [DATA_W-1:0]           ram_rdata;

    // Requesters plus RAM macro
    modport master (
        output req, we, addr, wdata, ram_rdata,
        input  ack, rdata, ram_addr, ram_wdata, ram_w
    );

    // Arbiter
    modport slave (
        input  req, we, addr, wdata, ram_rdata,
        output ack, rdata, ram_addr, ram_wdata, ram_w
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner selection: port 0 absolute, then starve override, then round-robin.
module ram_arb_pick import q16_mem_pkg::*; (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 rr_dma_i,   // round-robin pointer currently favours port 2
    input  logic                 starve_i,   // port 2 has lost too many times in a row
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 valid_o
);

    // One-hot grant from the current requests
    always_comb begin
        gnt_o = '0;
        if (req_i[P_INT]) begin
            gnt_o[P_INT] = 1'b1;
        end else if (req_i[P_CPU] && req_i[P_DMA]) begin
            if (starve_i || rr_dma_i) begin
                gnt_o[P_DMA] = 1'b1;
            end else begin
                gnt_o[P_CPU] = 1'b1;
            end
        end else if (req_i[P_CPU]) begin
            gnt_o[P_CPU] = 1'b1;
        end else if (req_i[P_DMA]) begin
            gnt_o[P_DMA] = 1'b1;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM among three requesters; sequences writes and latency-aware reads.
module ram_port_arbiter import q16_mem_pkg::*; #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);

    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
        $error("ram_port_arbiter: RD_LAT must be in the range 1..3");
    end

    localparam int unsigned   STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [1:0]    LAT_INIT   = 2'(RD_LAT - 1);

    arb_state_e             state_q, state_d;
    logic [1:0]             lat_q, lat_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic                   rr_dma_q, rr_dma_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
    logic                   ram_w_q, ram_w_d;

    logic [NUM_PORTS-1:0]   pick_gnt;
    logic                   pick_valid;
    logic                   starve_full;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   sel_we;

    assign starve_full = (starve_q >= STARVE_LIM);

    ram_arb_pick u_pick (
        .req_i    (bus.req),
        .rr_dma_i (rr_dma_q),
        .starve_i (starve_full),
        .gnt_o    (pick_gnt),
        .valid_o  (pick_valid)
    );

    // Mux the winning port's request fields
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_gnt[i]) begin
                sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
                sel_we    = bus.we[i];
            end
        end
    end

    // FSM next state, arbitration bookkeeping and registered outputs
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        gnt_d       = gnt_q;
        rr_dma_d    = rr_dma_q;
        starve_d    = starve_q;
        ack_d       = '0;
        rdata_d     = '0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_w_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d       = pick_gnt;
                    ram_addr_d  = sel_addr;
                    ram_wdata_d = sel_wdata;
                    ram_w_d     = sel_we;
                    // A write completes in the cycle its strobe is on the RAM
                    ack_d       = sel_we ? pick_gnt : '0;
                    if (pick_gnt[P_CPU] || pick_gnt[P_DMA]) begin
                        rr_dma_d = ~rr_dma_q;
                    end
                    if (pick_gnt[P_DMA]) begin
                        starve_d = '0;
                    end else if (bus.req[P_DMA] && !starve_full) begin
                        starve_d = starve_q + 1'b1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (ram_w_q) begin
                    state_d = StIdle;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = StRwait;
                end
            end
            StRwait: begin
                if (lat_q == 2'd0) begin
                    ack_d   = gnt_q;
                    rdata_d = bus.ram_rdata;
                    state_d = StIdle;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!bus.req[P_DMA]) begin
            starve_d = '0;
        end
    end

    // State and output registers; reset drops any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            gnt_q       <= '0;
            rr_dma_q    <= 1'b0;
            starve_q    <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_w_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            gnt_q       <= gnt_d;
            rr_dma_q    <= rr_dma_d;
            starve_q    <= starve_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_w_q     <= ram_w_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_w     = ram_w_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_ram_port_arbiter;

    localparam int AW         = 16;
    localparam int DW         = 16;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 3;
    localparam int SZ         = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Unwritten RAM locations read back a fixed address-derived pattern
    function automatic bit [15:0] fill(input bit [15:0] a);
        return a ^ 16'h1276;
    endfunction

    // RAM macro: synchronous write, RD_LAT-cycle read pipeline
    bit [15:0] env_mem [65536];
    bit        env_vld [65536];
    bit [15:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (bus.ram_w === 1'b1) begin
            env_mem[bus.ram_addr] <= bus.ram_wdata;
            env_vld[bus.ram_addr] <= 1'b1;
        end
        rd_pipe[0] <= env_vld[bus.ram_addr] ? env_mem[bus.ram_addr] : fill(bus.ram_addr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.ram_rdata = rd_pipe[RD_LAT-1];

    // Transaction-level reference: expected outputs scheduled per cycle
    int        cyc = 0;
    bit [2:0]  e_ack   [SZ];
    bit [15:0] e_rdata [SZ];
    bit        e_w     [SZ];
    bit        e_av    [SZ];
    bit [15:0] e_addr  [SZ];
    bit [15:0] e_wdata [SZ];
    bit [15:0] ref_mem [65536];
    bit        ref_vld [65536];
    int        next_pick = 0;
    bit        m_fav2    = 1'b0;
    int        m_starve  = 0;
    bit [2:0]  m_inflight = '0;
    bit [2:0]  m_acked    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : model
        int n, idx, win, pn;
        bit [15:0] a, d;
        bit [2:0] oh;
        n   = cyc;
        idx = n % SZ;
        if (!rst_n) begin
            chk("rst_ack", 32'(bus.ack), 32'd0);
            chk("rst_ram_w", 32'(bus.ram_w), 32'd0);
            chk("rst_rdata", 32'(bus.rdata), 32'd0);
            for (int i = 0; i < SZ; i++) begin
                e_ack[i] = '0; e_rdata[i] = '0; e_w[i] = 1'b0; e_av[i] = 1'b0;
            end
            next_pick  = n + 1;
            m_fav2     = 1'b0;
            m_starve   = 0;
            m_inflight = '0;
            m_acked    = '0;
        end else begin
            chk("ack", 32'(bus.ack), 32'(e_ack[idx]));
            chk("rdata", 32'(bus.rdata), 32'(e_rdata[idx]));
            chk("ram_w", 32'(bus.ram_w), 32'(e_w[idx]));
            if (e_av[idx]) begin
                chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr[idx]));
                if (e_w[idx]) chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata[idx]));
            end
            m_acked    = e_ack[idx];
            m_inflight = m_inflight & ~e_ack[idx];
            e_ack[idx] = '0; e_rdata[idx] = '0; e_w[idx] = 1'b0; e_av[idx] = 1'b0;
            if (n == next_pick) begin
                if (bus.req != 3'b000) begin
                    if (bus.req[0]) win = 0;
                    else if (bus.req[1] && bus.req[2]) win = (m_starve >= STARVE_MAX || m_fav2) ? 2 : 1;
                    else win = bus.req[1] ? 1 : 2;
                    if (win != 0) m_fav2 = !m_fav2;
                    if (win == 2) m_starve = 0;
                    else if (bus.req[2] && m_starve < STARVE_MAX) m_starve++;
                    a  = bus.addr[win*16 +: 16];
                    d  = bus.wdata[win*16 +: 16];
                    oh = '0;
                    oh[win] = 1'b1;
                    m_inflight[win] = 1'b1;
                    pn = (n + 1) % SZ;
                    e_av[pn]   = 1'b1;
                    e_addr[pn] = a;
                    if (bus.we[win]) begin
                        e_w[pn]     = 1'b1;
                        e_wdata[pn] = d;
                        e_ack[pn]   = oh;
                        ref_mem[a]  = d;
                        ref_vld[a]  = 1'b1;
                        next_pick   = n + 2;
                    end else begin
                        pn = (n + 2 + RD_LAT) % SZ;
                        e_ack[pn]   = oh;
                        e_rdata[pn] = ref_vld[a] ? ref_mem[a] : fill(a);
                        next_pick   = n + 2 + RD_LAT;
                    end
                end else begin
                    next_pick = n + 1;
                end
            end
            if (!bus.req[2]) m_starve = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input bit [15:0] a,
                            input bit [15:0] d);
        bus.req[p]           = r;
        bus.we[p]            = w;
        bus.addr[p*16 +: 16]  = a;
        bus.wdata[p*16 +: 16] = d;
    endtask

    task automatic new_txn(input int p);
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom));
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst_n   = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Returns the acked port, or -1 if none arrives within the budget
    task automatic wait_ack(input int budget, output int port);
        port = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.ack != 3'b000) begin
                port = bus.ack[0] ? 0 : (bus.ack[1] ? 1 : 2);
                break;
            end
        end
    endtask

    initial begin
        int port;
        int cnt;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_ack", 32'(bus.ack), 32'd0);
        chk("reset_ram_w", 32'(bus.ram_w), 32'd0);
        chk("reset_rdata", 32'(bus.rdata), 32'd0);
        chk("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("reset_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        step();
        rst_n = 1'b1;

        // Single write on port 1
        set_port(1, 1'b1, 1'b1, 16'h1310, 16'hBEEF);
        @(negedge clk);
        chk("wr_c_ram_w", 32'(bus.ram_w), 32'd0);
        @(negedge clk);
        chk("wr_c1_ram_w", 32'(bus.ram_w), 32'd1);
        chk("wr_c1_addr", 32'(bus.ram_addr), 32'h1310);
        chk("wr_c1_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        chk("wr_c1_ack", 32'(bus.ack), 32'b010);
        step();
        bus.req = '0;
        @(negedge clk);
        chk("wr_c2_ram_w", 32'(bus.ram_w), 32'd0);
        chk("wr_c2_ack", 32'(bus.ack), 32'd0);
        repeat (3) step();

        // Read on port 0, data back in C+4
        set_port(0, 1'b1, 1'b0, 16'h0042, 16'h0000);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("rd_ram_w", 32'(bus.ram_w), 32'd0);
            chk("rd_ack", 32'(bus.ack), (k == 4) ? 32'b001 : 32'd0);
            chk("rd_rdata", 32'(bus.rdata), (k == 4) ? 32'h1234 : 32'd0);
        end
        step();
        bus.req = '0;
        repeat (8) step();

        // Contention: p0 first, then p1/p2 alternate
        do_reset();
        set_port(0, 1'b1, 1'b1, 16'h0010, 16'h1111);
        set_port(1, 1'b1, 1'b1, 16'h0011, 16'h2222);
        set_port(2, 1'b1, 1'b1, 16'h0012, 16'h3333);
        for (int k = 0; k < 2; k++) begin
            wait_ack(10, port);
            chk("cont_p0", 32'(port), 32'd0);
            step();
        end
        bus.req[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(10, port);
            chk("cont_rr", 32'(port), (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
        end
        bus.req = '0;
        repeat (4) step();

        // Reset during RWAIT, then a fresh request
        set_port(1, 1'b1, 1'b0, 16'h0077, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        step();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rstrd_ram_w", 32'(bus.ram_w), 32'd0);
            chk("rstrd_ack", 32'(bus.ack), 32'd0);
            step();
        end
        bus.req = '0;
        rst_n   = 1'b1;
        set_port(2, 1'b1, 1'b1, 16'h0033, 16'h5A5A);
        @(negedge clk);
        chk("fresh_c_ack", 32'(bus.ack), 32'd0);
        @(negedge clk);
        chk("fresh_c1_ack", 32'(bus.ack), 32'b100);
        chk("fresh_c1_ram_w", 32'(bus.ram_w), 32'd1);
        chk("fresh_c1_addr", 32'(bus.ram_addr), 32'h0033);
        step();
        bus.req = '0;
        repeat (3) step();

        // Starvation: three p0 wins push p2 past the limit while RR favours p1
        do_reset();
        set_port(0, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
        set_port(1, 1'b1, 1'b1, 16'h0021, 16'hBBBB);
        set_port(2, 1'b1, 1'b1, 16'h0022, 16'hCCCC);
        for (int k = 0; k < 3; k++) begin
            wait_ack(10, port);
            chk("starve_p0", 32'(port), 32'd0);
            step();
        end
        bus.req[0] = 1'b0;
        wait_ack(10, port);
        chk("starve_p2_wins", 32'(port), 32'd2);
        step();
        bus.req = '0;
        repeat (4) step();

        // Withdraw in ISSUE: one ack, no re-issue
        set_port(2, 1'b1, 1'b0, 16'h0055, 16'h0000);
        @(negedge clk);
        step();
        bus.req[2] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.ack[2] === 1'b1) cnt++;
        end
        chk("withdraw_acks", 32'(cnt), 32'd1);
        step();

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            step();
            for (int p = 0; p < 3; p++) begin
                if (m_acked[p]) begin
                    if ($urandom_range(0, 1) == 0) bus.req[p] = 1'b0;
                    else new_txn(p);
                end else if (!bus.req[p] && !m_inflight[p]) begin
                    if ($urandom_range(0, (p == 0) ? 7 : 2) == 0) new_txn(p);
                end else if (bus.req[p] && m_inflight[p] && $urandom_range(0, 15) == 0) begin
                    bus.req[p] = 1'b0;
                end
            end
        end
        bus.req = '0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
